ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
- Multi-master bus arbiter in front of the AHB interconnect.
- Decides which master drives the shared address/control path. Publishes HGRANT, the address-phase owner (HMASTER) and the data-phase owner (HMASTER_D), which steer the master-side muxes.
- Round-robin fairness. Fixed-length bursts are never broken. HLOCK holds the bus.

Parameters:
- MASTER_COUNT, 4, number of requesting masters (2..16).
- DEFAULT_MASTER, 0, master granted when no master is requesting.
- MIDX_W, $clog2(MASTER_COUNT), width of master index (derived; do not override).

Ports:
- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESET  in  1  synchronous active-high reset.
- HBUSREQ  in  MASTER_COUNT  per-master bus request.
- HLOCK  in  MASTER_COUNT  per-master locked-transfer request.
- HTRANS  in  2  transfer type of the currently granted master (post-mux).
- HBURST  in  3  burst type of the currently granted master (post-mux).
- HREADY  in  1  bus ready from the interconnect response mux.
- HGRANT  out  MASTER_COUNT  one-hot grant.
- HMASTER  out  MIDX_W  index of the address-phase owner.
- HMASTER_D  out  MIDX_W  index of the data-phase owner; steers the HWDATA mux.
- HMASTLOCK  out  1  current address phase is locked.

Behaviour:
- Interface: one clock, HCLK. Reset HRESET is synchronous and active-high.
- Reset values:
  - HGRANT = one-hot(DEFAULT_MASTER).
  - HMASTER = HMASTER_D = DEFAULT_MASTER.
  - HMASTLOCK = 0.
  - Beat counter = 0. State = ARB.
- Reset mid-burst aborts the burst immediately.
- HGRANT always equals one-hot(HMASTER); exactly one bit is set at all times.
- Beat qualifier: acc = HREADY & HTRANS[1], i.e. NONSEQ (2'b10) or SEQ (2'b11) accepted. BUSY and IDLE never count.
- Burst length from HBURST:
  - SINGLE = 1, INCR = undefined.
  - WRAP4/INCR4 (2/3) = 4.
  - WRAP8/INCR8 (4/5) = 8.
  - WRAP16/INCR16 (6/7) = 16.
- State machine:
  - ARB: rearbitration allowed on every cycle with HREADY=1. If acc and HTRANS=NONSEQ and HBURST is fixed-length: load cnt = len-1 and go to BURST.
  - BURST: grant frozen. Each acc decrements cnt.
    - When cnt==1 and acc (last beat address accepted), return to ARB; rearbitration takes effect on this same edge.
    - HTRANS=IDLE with HREADY=1 (early termination after ERROR): go to ARB and rearbitrate on the same edge.
    - HTRANS=NONSEQ inside BURST (protocol-abnormal): treat as a new burst start and reload cnt.
- Arbitration decision (registered, updated only when HREADY=1 and state permits):
  - If HLOCK[HMASTER] & HBUSREQ[HMASTER]: keep the current master.
  - Else round-robin search starting at index (HMASTER+1) mod MASTER_COUNT, wrapping. The first requester wins. The current master competes last.
  - No requester: grant DEFAULT_MASTER.
- Grant latency: a request sampled at edge N produces HGRANT at edge N+1 at earliest, gated by HREADY and burst state.
- HMASTER_D <= HMASTER on every edge with HREADY=1; held while HREADY=0.
- HMASTLOCK <= HLOCK[next owner] on edges where the grant updates; held otherwise.
- HREADY=0: all outputs and counters hold.
- Simultaneous request drop and burst end: the arbiter follows the values sampled on that edge, with no extra idle cycle.

Optional Feature:
- Macro: AHB_ARB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority; the lowest requesting index wins. Lock and burst rules are unchanged.
- Undefined: round-robin as specified.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE, BUSY, NONSEQ, SEQ.
  - HBURST encodings.
  - burst_len function mapping HBURST to beat count (0 = undefined).
  - HRESP encodings.
- One sub-module: ahb_rr_picker. Combinational round-robin priority encoder; inputs are request vector and last-grant index; output is winner index plus valid. The fixed-priority variant is selected inside it under the macro.

Test Plan:
- Reset then idle: HRESET=1 for 2 cycles, HBUSREQ=0 -> HGRANT=4'b0001, HMASTER=0, HMASTER_D=0, HMASTLOCK=0.
- Round-robin: HBUSREQ=4'b1111 with SINGLE NONSEQ transfers and HREADY=1 -> HMASTER sequence 1,2,3,0,1 on consecutive edges.
- Burst hold: master 2 issues INCR4 (HBURST=3'b011) with 4 accepted beats while master 1 requests -> HMASTER stays 2 for all 4 beats; becomes 1 on the edge accepting beat 4.
- Wait states: HREADY=0 for 3 cycles during a WRAP8 burst -> counter and HMASTER hold; burst ends after exactly 8 accepted beats.
- Lock: master 3 with HLOCK[3]=1 and HBUSREQ=4'b1001 -> HMASTER stays 3 and HMASTLOCK=1 until HLOCK[3] drops; then master 0 is granted.
- Early termination: HTRANS=IDLE after 2 beats of an INCR16 -> return to ARB on that edge; the next requester is granted.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings (HTRANS, HBURST, HRESP) and the burst-length lookup
// used by the arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    // Beat count of a burst; 0 means undefined length (INCR).
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE:               return 5'd1;
            HBURST_WRAP4, HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8, HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                     return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational request picker: round-robin after the last grant by default,
// lowest index wins when AHB_ARB_FIXED_PRIO_EN is defined.
module ahb_rr_picker #(
    parameter int MASTER_COUNT = 4,
    parameter int MIDX_W       = $clog2(MASTER_COUNT)
) (
    input  logic [MASTER_COUNT-1:0] req,
    input  logic [MIDX_W-1:0]       last,
    output logic [MIDX_W-1:0]       winner,
    output logic                    valid
);

    logic [MIDX_W-1:0] idx;

    // NOTE: every variable written here gets a default first so no path can infer a latch.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int i = MASTER_COUNT - 1; i >= 0; i--) begin
            idx = MIDX_W'(i);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
`else
        // Descending scan so the nearest requester after 'last' is written last;
        // offset MASTER_COUNT is 'last' itself, which therefore competes last.
        for (int i = MASTER_COUNT; i >= 1; i--) begin
            idx = MIDX_W'((int'(last) + i) % MASTER_COUNT);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
`endif
    end

`ifdef AHB_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;
`endif

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant, fixed-length bursts held to completion,
// HLOCK keeps the owner. Define AHB_ARB_FIXED_PRIO_EN for fixed priority.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int MASTER_COUNT   = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MIDX_W         = $clog2(MASTER_COUNT)
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [MASTER_COUNT-1:0] HBUSREQ,
    input  logic [MASTER_COUNT-1:0] HLOCK,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HBURST,
    input  logic                    HREADY,
    output logic [MASTER_COUNT-1:0] HGRANT,
    output logic [MIDX_W-1:0]       HMASTER,
    output logic [MIDX_W-1:0]       HMASTER_D,
    output logic                    HMASTLOCK
);

    localparam logic [0:0]        ST_ARB   = 1'b0;
    localparam logic [0:0]        ST_BURST = 1'b1;
    localparam logic [MIDX_W-1:0] DEF_IDX  = MIDX_W'(DEFAULT_MASTER);

    logic [0:0]              state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [MIDX_W-1:0]       master_q, master_d;
    logic [MIDX_W-1:0]       master_dp_q, master_dp_d;
    logic [MASTER_COUNT-1:0] grant_q, grant_d;
    logic                    mastlock_q, mastlock_d;

    logic              acc, is_nonseq, fixed_len, rearb, pick_valid;
    logic [4:0]        len;
    logic [MIDX_W-1:0] pick_idx, next_owner;

    ahb_rr_picker #(
        .MASTER_COUNT(MASTER_COUNT),
        .MIDX_W      (MIDX_W)
    ) u_picker (
        .req   (HBUSREQ),
        .last  (master_q),
        .winner(pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        acc       = HREADY & HTRANS[1];
        is_nonseq = (HTRANS == HTRANS_NONSEQ);
        len       = burst_len(HBURST);
        fixed_len = (len > 5'd1);
        if (HLOCK[master_q] & HBUSREQ[master_q]) begin
            next_owner = master_q;
        end else if (pick_valid) begin
            next_owner = pick_idx;
        end else begin
            next_owner = DEF_IDX;
        end
    end

    // A burst start keeps the grant on its own edge; the issuing master owns the beats that follow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rearb   = 1'b0;
        if (HREADY) begin
            if (acc && is_nonseq && fixed_len) begin
                state_d = ST_BURST;
                cnt_d   = 4'(len - 5'd1);
            end else if (state_q == ST_ARB) begin
                rearb = 1'b1;
            end else if ((acc && (is_nonseq || cnt_q == 4'd1)) || HTRANS == HTRANS_IDLE) begin
                state_d = ST_ARB;
                cnt_d   = 4'd0;
                rearb   = 1'b1;
            end else if (acc) begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        master_d    = master_q;
        grant_d     = grant_q;
        mastlock_d  = mastlock_q;
        master_dp_d = HREADY ? master_q : master_dp_q;
        if (rearb) begin
            master_d   = next_owner;
            grant_d    = MASTER_COUNT'(1) << next_owner;
            mastlock_d = HLOCK[next_owner];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_ARB;
            cnt_q       <= 4'd0;
            master_q    <= DEF_IDX;
            master_dp_q <= DEF_IDX;
            grant_q     <= MASTER_COUNT'(1) << DEF_IDX;
            mastlock_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            master_q    <= master_d;
            master_dp_q <= master_dp_d;
            grant_q     <= grant_d;
            mastlock_q  <= mastlock_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTER_D = master_dp_q;
    assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed vector table, hand-written
// burst/lock/wait-state sequences, then random traffic against a reference model.
module tb_ahb_arbiter;

    logic       HCLK, HRESET, HREADY, HMASTLOCK;
    logic [3:0] HBUSREQ, HLOCK, HGRANT;
    logic [1:0] HTRANS, HMASTER, HMASTER_D;
    logic [2:0] HBURST;

    int tests_run = 0;
    int tests_failed = 0;

    ahb_arbiter #(.MASTER_COUNT(4), .DEFAULT_MASTER(0)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HGRANT(HGRANT),
        .HMASTER(HMASTER), .HMASTER_D(HMASTER_D), .HMASTLOCK(HMASTLOCK)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Reference model: owner, data-phase owner, lock flag, beats still owed by the open burst.
    int m_owner = 0, m_down = 0, m_left = 0;
    bit m_lock = 1'b0;

    function automatic int blen(input logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd1:       return 0;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    function automatic bit bit_of(input logic [3:0] v, input int i);
        return ((v >> i) & 4'b0001) != 4'b0000;
    endfunction

    function automatic int pick(input int cur, input logic [3:0] req);
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) if (bit_of(req, k)) return k;
`else
        for (int k = 1; k <= 4; k++) if (bit_of(req, (cur + k) % 4)) return (cur + k) % 4;
`endif
        return 0;
    endfunction

    task automatic model_edge();
        int prev;
        bit regrant;
        if (HRESET) begin
            m_owner = 0; m_down = 0; m_lock = 1'b0; m_left = 0;
            return;
        end
        if (!HREADY) return;
        prev = m_owner;
        regrant = 1'b0;
        if (HTRANS == 2'b10 && blen(HBURST) > 1) begin
            m_left = blen(HBURST) - 1;
        end else if (m_left == 0) begin
            regrant = 1'b1;
        end else if (HTRANS == 2'b00 || HTRANS == 2'b10) begin
            m_left = 0;
            regrant = 1'b1;
        end else if (HTRANS == 2'b11) begin
            m_left = m_left - 1;
            regrant = (m_left == 0);
        end
        if (regrant) begin
            if (!(bit_of(HLOCK, m_owner) && bit_of(HBUSREQ, m_owner)))
                m_owner = (HBUSREQ != 4'b0000) ? pick(m_owner, HBUSREQ) : 0;
            m_lock = bit_of(HLOCK, m_owner);
        end
        m_down = prev;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int m, input int d, input bit l);
        check({tag, " HMASTER"}, 32'(HMASTER), 32'(m));
        check({tag, " HMASTER_D"}, 32'(HMASTER_D), 32'(d));
        check({tag, " HGRANT"}, 32'(HGRANT), 32'(1) << m);
        check({tag, " HMASTLOCK"}, 32'(HMASTLOCK), 32'(l));
    endtask

    // Drive inputs away from the edge, take one rising edge, then settle before sampling.
    task automatic drive(input bit rst, input logic [3:0] req, input logic [3:0] lock,
                         input logic [1:0] tr, input logic [2:0] bu, input bit rdy);
        HRESET = rst; HBUSREQ = req; HLOCK = lock; HTRANS = tr; HBURST = bu; HREADY = rdy;
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] tr;
        logic [2:0] bu;
        bit         rdy;
        int         m;
        int         d;
        bit         l;
    } vec_t;

    vec_t vecs[13];

    initial begin
        HRESET = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = 2'b00; HBURST = 3'd0; HREADY = 1'b1;

        // Reset, idle, round-robin over SINGLE transfers, then an INCR4 held by master 2.
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 3'd0, 1'b1, 0, 0, 1'b0};
        vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 3'd0, 1'b1, 0, 0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 2'b00, 3'd0, 1'b1, 0, 0, 1'b0};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 2'b10, 3'd0, 1'b1, 1, 0, 1'b0};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 2'b10, 3'd0, 1'b1, 2, 1, 1'b0};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0000, 2'b10, 3'd0, 1'b1, 3, 2, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 4'b0000, 2'b10, 3'd0, 1'b1, 0, 3, 1'b0};
        vecs[7]  = '{1'b0, 4'b1111, 4'b0000, 2'b10, 3'd0, 1'b1, 1, 0, 1'b0};
        vecs[8]  = '{1'b0, 4'b0100, 4'b0000, 2'b00, 3'd0, 1'b1, 2, 1, 1'b0};
        vecs[9]  = '{1'b0, 4'b0110, 4'b0000, 2'b10, 3'd3, 1'b1, 2, 2, 1'b0};
        vecs[10] = '{1'b0, 4'b0110, 4'b0000, 2'b11, 3'd3, 1'b1, 2, 2, 1'b0};
        vecs[11] = '{1'b0, 4'b0110, 4'b0000, 2'b11, 3'd3, 1'b1, 2, 2, 1'b0};
        vecs[12] = '{1'b0, 4'b0110, 4'b0000, 2'b11, 3'd3, 1'b1, 1, 2, 1'b0};

        #2;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].tr, vecs[i].bu, vecs[i].rdy);
            check_all($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].l);
        end

        // WRAP8 by master 1 with three wait states after beat 3: exactly 8 beats hold the grant.
        drive(1'b0, 4'b0011, 4'b0000, 2'b10, 3'd4, 1'b1);
        check_all("wrap8 beat1", 1, 1, 1'b0);
        for (int b = 2; b <= 3; b++) begin
            drive(1'b0, 4'b0011, 4'b0000, 2'b11, 3'd4, 1'b1);
            check_all($sformatf("wrap8 beat%0d", b), 1, 1, 1'b0);
        end
        for (int w = 0; w < 3; w++) begin
            drive(1'b0, 4'b0011, 4'b0000, 2'b11, 3'd4, 1'b0);
            check_all($sformatf("wrap8 wait%0d", w), 1, 1, 1'b0);
        end
        for (int b = 4; b <= 7; b++) begin
            drive(1'b0, 4'b0011, 4'b0000, 2'b11, 3'd4, 1'b1);
            check_all($sformatf("wrap8 beat%0d", b), 1, 1, 1'b0);
        end
        drive(1'b0, 4'b0011, 4'b0000, 2'b11, 3'd4, 1'b1);
        check_all("wrap8 beat8", 0, 1, 1'b0);

        // Locked master 3 keeps the bus until HLOCK[3] drops.
        drive(1'b0, 4'b1000, 4'b1000, 2'b00, 3'd0, 1'b1);
        check_all("lock grant", 3, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b1001, 4'b1000, 2'b10, 3'd0, 1'b1);
            check_all($sformatf("lock hold%0d", k), 3, 3, 1'b1);
        end
        drive(1'b0, 4'b1001, 4'b0000, 2'b10, 3'd0, 1'b1);
        check_all("lock release", 0, 3, 1'b0);

        // INCR16 terminated by IDLE after 2 beats rearbitrates on that edge.
        drive(1'b0, 4'b0101, 4'b0000, 2'b10, 3'd7, 1'b1);
        check_all("incr16 beat1", 0, 0, 1'b0);
        drive(1'b0, 4'b0101, 4'b0000, 2'b11, 3'd7, 1'b1);
        check_all("incr16 beat2", 0, 0, 1'b0);
        drive(1'b0, 4'b0101, 4'b0000, 2'b00, 3'd7, 1'b1);
        check_all("incr16 early end", 2, 0, 1'b0);

        // Reset during an INCR8 aborts it: a following SEQ no longer holds the grant.
        drive(1'b0, 4'b0110, 4'b0000, 2'b10, 3'd5, 1'b1);
        check_all("incr8 start", 2, 2, 1'b0);
        drive(1'b0, 4'b0110, 4'b0000, 2'b11, 3'd5, 1'b1);
        check_all("incr8 beat2", 2, 2, 1'b0);
        drive(1'b1, 4'b0110, 4'b0000, 2'b11, 3'd5, 1'b1);
        check_all("mid-burst reset", 0, 0, 1'b0);
        drive(1'b0, 4'b0100, 4'b0000, 2'b11, 3'd5, 1'b1);
        check_all("after reset", 2, 0, 1'b0);

        // Random traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 99) == 0,
                  4'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                  2'($urandom),
                  3'($urandom),
                  $urandom_range(0, 3) != 0);
            check_all($sformatf("rand%0d", c), m_owner, m_down, m_lock);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
